// File: rtl/sram_rw_arbiter.sv
// sram_rw_arbiter
//   Shares one single-port, byte-masked RW SRAM macro between two requesters.
//   Round-robin arbitration gives at most one memory access per cycle.
//   Reads return data one cycle after acceptance on a fire-and-forget
//   response channel. Writes produce no response.
//
// Parameters
//   ADDR_W  word address width (depth = 2**ADDR_W)
//   DATA_W  data width
//   MASK_W  byte-enable width, must equal DATA_W/8
//
// Ports
//   clock, reset                    rising-edge clock, synchronous active-high reset
//   reqN_valid/ready                request handshake; accepted on valid & ready
//   reqN_addr/write/wmask/wdata     request payload (wmask ignored on reads)
//   respN_valid/rdata               one-cycle read response, no backpressure
//   mem_en/wmode/addr/wmask/wdata   drive the macro RW0 port
//   mem_rdata                       macro RW0 read data (1-cycle latency)
//   init_done                       block is accepting requests
//
// Optional build macro
//   SRAM_ARB_ZERO_INIT_EN  after reset, sweep the whole memory writing zeros
//                          (one word per cycle) before accepting requests.
module sram_rw_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int MASK_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic              req0_write,
  input  logic [MASK_W-1:0] req0_wmask,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              resp0_valid,
  output logic [DATA_W-1:0] resp0_rdata,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic              req1_write,
  input  logic [MASK_W-1:0] req1_wmask,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              resp1_valid,
  output logic [DATA_W-1:0] resp1_rdata,
  output logic              mem_en,
  output logic              mem_wmode,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [MASK_W-1:0] mem_wmask,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              init_done
);

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

`ifdef SRAM_ARB_ZERO_INIT_EN
  localparam state_t RESET_STATE = ST_INIT;
`else
  localparam state_t RESET_STATE = ST_RUN;
`endif

  state_t state_q, state_d;
`ifdef SRAM_ARB_ZERO_INIT_EN
  logic [ADDR_W-1:0] init_cnt_q, init_cnt_d;
`endif
  // last_q: requester granted most recently; resets to 1 so requester 0 wins first.
  logic              last_q, last_d;
  logic              pend_q, pend_d;
  logic              owner_q, owner_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;

  logic grant;
  logic accept;

  always_comb begin
    state_d     = state_q;
`ifdef SRAM_ARB_ZERO_INIT_EN
    init_cnt_d  = init_cnt_q;
`endif
    last_d      = last_q;
    pend_d      = 1'b0;
    owner_d     = owner_q;
    grant       = 1'b0;
    accept      = 1'b0;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    mem_en      = 1'b0;
    mem_wmode   = 1'b0;
    mem_addr    = '0;
    mem_wmask   = '0;
    mem_wdata   = '0;
    init_done   = 1'b0;

    // Reset is a synchronous input, so registered state is still live during
    // the first reset cycle; gate every output with it directly.
    resp0_valid = pend_q & ~owner_q & ~reset;
    resp1_valid = pend_q &  owner_q & ~reset;

    // Response data is bypassed from the macro in the valid cycle and held
    // from a shadow register otherwise.
    rdata0_d    = resp0_valid ? mem_rdata : rdata0_q;
    rdata1_d    = resp1_valid ? mem_rdata : rdata1_q;
    resp0_rdata = rdata0_d;
    resp1_rdata = rdata1_d;

    if (reset) begin
      // all outputs stay at their idle defaults
    end else if (state_q == ST_INIT) begin
`ifdef SRAM_ARB_ZERO_INIT_EN
      mem_en     = 1'b1;
      mem_wmode  = 1'b1;
      mem_addr   = init_cnt_q;
      mem_wmask  = '1;
      init_cnt_d = init_cnt_q + 1'b1;
      if (init_cnt_q == '1) begin
        state_d = ST_RUN;
      end
`endif
    end else begin
      init_done = 1'b1;
      if (req0_valid && req1_valid) begin
        grant = ~last_q;
      end else begin
        grant = req1_valid;
      end
      accept     = req0_valid | req1_valid;
      req0_ready = accept & ~grant;
      req1_ready = accept &  grant;
      if (accept) begin
        mem_en    = 1'b1;
        mem_wmode = grant ? req1_write : req0_write;
        mem_addr  = grant ? req1_addr  : req0_addr;
        mem_wmask = grant ? req1_wmask : req0_wmask;
        mem_wdata = grant ? req1_wdata : req0_wdata;
        last_d    = grant;
        pend_d    = ~mem_wmode;
        owner_d   = grant;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= RESET_STATE;
`ifdef SRAM_ARB_ZERO_INIT_EN
      init_cnt_q <= '0;
`endif
      last_q     <= 1'b1;
      pend_q     <= 1'b0;
      owner_q    <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      state_q    <= state_d;
`ifdef SRAM_ARB_ZERO_INIT_EN
      init_cnt_q <= init_cnt_d;
`endif
      last_q     <= last_d;
      pend_q     <= pend_d;
      owner_q    <= owner_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
    end
  end

endmodule

// File: tb/tb_sram_rw_arbiter.sv
// tb_sram_rw_arbiter
//   Randomized and directed stimulus for sram_rw_arbiter, checked against a
//   reference model of the arbitration rules and a flat array of memory
//   contents. A behavioural SRAM macro model sits on the mem_* ports.
module tb_sram_rw_arbiter;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int MW = 4;
`ifdef SRAM_ARB_ZERO_INIT_EN
  localparam int INIT_CYCLES = 256;
`else
  localparam int INIT_CYCLES = 0;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          req0_valid = 1'b0, req0_write = 1'b0;
  logic [AW-1:0] req0_addr = '0;
  logic [MW-1:0] req0_wmask = '0;
  logic [DW-1:0] req0_wdata = '0;
  logic          req1_valid = 1'b0, req1_write = 1'b0;
  logic [AW-1:0] req1_addr = '0;
  logic [MW-1:0] req1_wmask = '0;
  logic [DW-1:0] req1_wdata = '0;
  logic          req0_ready, req1_ready, resp0_valid, resp1_valid;
  logic [DW-1:0] resp0_rdata, resp1_rdata;
  logic          mem_en, mem_wmode, init_done;
  logic [AW-1:0] mem_addr;
  logic [MW-1:0] mem_wmask;
  logic [DW-1:0] mem_wdata, mem_rdata;

  always #5 clock = ~clock;

  sram_rw_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MASK_W(MW)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr),
    .req0_write(req0_write), .req0_wmask(req0_wmask), .req0_wdata(req0_wdata),
    .resp0_valid(resp0_valid), .resp0_rdata(resp0_rdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr),
    .req1_write(req1_write), .req1_wmask(req1_wmask), .req1_wdata(req1_wdata),
    .resp1_valid(resp1_valid), .resp1_rdata(resp1_rdata),
    .mem_en(mem_en), .mem_wmode(mem_wmode), .mem_addr(mem_addr),
    .mem_wmask(mem_wmask), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .init_done(init_done)
  );

  // Behavioural SRAM macro: masked write, registered read, 1-cycle latency.
  logic [DW-1:0] sram [256];
  logic [DW-1:0] sram_rdata;
  assign mem_rdata = sram_rdata;
  always @(posedge clock) begin
    if (mem_en) begin
      if (mem_wmode) begin
        for (int b = 0; b < MW; b++) begin
          if (mem_wmask[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
      end else begin
        sram_rdata <= sram[mem_addr];
      end
    end
  end

  // Reference model state
  logic [DW-1:0] ref_mem [256];
  bit            m_last = 1'b1;
  bit            m_pend = 1'b0;
  bit            m_owner = 1'b0;
  logic [DW-1:0] m_pdata = '0;
  int            m_init_left = 0;
  logic [DW-1:0] last_r0 = '0, last_r1 = '0;
  bit            grants[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w, input logic [DW-1:0] new_w,
                                          input logic [MW-1:0] m);
    logic [DW-1:0] r;
    r = old_w;
    for (int b = 0; b < MW; b++) begin
      if (m[b]) r[8*b +: 8] = new_w[8*b +: 8];
    end
    return r;
  endfunction

  // One clock cycle: drive inputs at negedge, check 1 time unit later,
  // then advance the reference model to the state after the coming posedge.
  task automatic cycle(input bit rst,
                       input bit v0, input bit w0, input logic [AW-1:0] a0,
                       input logic [MW-1:0] k0, input logic [DW-1:0] d0,
                       input bit v1, input bit w1, input logic [AW-1:0] a1,
                       input logic [MW-1:0] k1, input logic [DW-1:0] d1);
    bit            g, w;
    logic [AW-1:0] a;
    logic [MW-1:0] k;
    logic [DW-1:0] d;
    @(negedge clock);
    reset = rst;
    req0_valid = v0; req0_write = w0; req0_addr = a0; req0_wmask = k0; req0_wdata = d0;
    req1_valid = v1; req1_write = w1; req1_addr = a1; req1_wmask = k1; req1_wdata = d1;
    #1;
    if (rst) begin
      chk("rst_ready0", 64'(req0_ready), 64'(0));
      chk("rst_ready1", 64'(req1_ready), 64'(0));
      chk("rst_mem_en", 64'(mem_en), 64'(0));
      chk("rst_resp0_valid", 64'(resp0_valid), 64'(0));
      chk("rst_resp1_valid", 64'(resp1_valid), 64'(0));
      chk("rst_init_done", 64'(init_done), 64'(0));
      m_pend = 1'b0;
      m_last = 1'b1;
      m_init_left = INIT_CYCLES;
      return;
    end
    chk("resp0_valid", 64'(resp0_valid), 64'(m_pend && !m_owner));
    chk("resp1_valid", 64'(resp1_valid), 64'(m_pend && m_owner));
    if (m_pend) begin
      if (m_owner) chk("resp1_rdata", 64'(resp1_rdata), 64'(m_pdata));
      else         chk("resp0_rdata", 64'(resp0_rdata), 64'(m_pdata));
    end
    if (resp0_valid) last_r0 = resp0_rdata;
    if (resp1_valid) last_r1 = resp1_rdata;
    if (req0_ready) grants.push_back(1'b0);
    if (req1_ready) grants.push_back(1'b1);

    if (m_init_left > 0) begin
      a = AW'(INIT_CYCLES - m_init_left);
      chk("init_done_low", 64'(init_done), 64'(0));
      chk("init_ready0", 64'(req0_ready), 64'(0));
      chk("init_ready1", 64'(req1_ready), 64'(0));
      chk("init_mem_en", 64'(mem_en), 64'(1));
      chk("init_wmode", 64'(mem_wmode), 64'(1));
      chk("init_addr", 64'(mem_addr), 64'(a));
      chk("init_wmask", 64'(mem_wmask), 64'(4'hF));
      chk("init_wdata", 64'(mem_wdata), 64'(0));
      ref_mem[a] = '0;
      m_init_left--;
      m_pend = 1'b0;
      return;
    end

    chk("init_done", 64'(init_done), 64'(1));
    // Sole requester wins; on contention the one not granted last wins.
    if (v0 && v1)  g = !m_last;
    else if (v1)   g = 1'b1;
    else           g = 1'b0;
    chk("ready0", 64'(req0_ready), 64'((v0 || v1) && !g));
    chk("ready1", 64'(req1_ready), 64'((v0 || v1) && g));
    chk("mem_en", 64'(mem_en), 64'(v0 || v1));
    if (v0 || v1) begin
      w = g ? w1 : w0;
      a = g ? a1 : a0;
      k = g ? k1 : k0;
      d = g ? d1 : d0;
      chk("mem_wmode", 64'(mem_wmode), 64'(w));
      chk("mem_addr", 64'(mem_addr), 64'(a));
      chk("mem_wmask", 64'(mem_wmask), 64'(k));
      chk("mem_wdata", 64'(mem_wdata), 64'(d));
      if (w) begin
        ref_mem[a] = merge(ref_mem[a], d, k);
        m_pend = 1'b0;
      end else begin
        m_pend  = 1'b1;
        m_owner = g;
        m_pdata = ref_mem[a];
      end
      m_last = g;
    end else begin
      m_pend = 1'b0;
    end
  endtask

  task automatic idle(input bit rst);
    cycle(rst, 0, 0, '0, '0, '0, 0, 0, '0, '0, '0);
  endtask

  task automatic wait_init();
    for (int i = 0; i < 300 && m_init_left > 0; i++) idle(1'b0);
    chk("init_complete", 64'(m_init_left), 64'(0));
  endtask

  task automatic rand_cycle();
    bit rst;
    rst = ($urandom_range(0, 49) == 0);
    cycle(rst,
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)),
          MW'($urandom), DW'($urandom),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)),
          MW'($urandom), DW'($urandom));
  endtask

  initial begin
    idle(1'b1);
    idle(1'b1);
    wait_init();

`ifdef SRAM_ARB_ZERO_INIT_EN
    cycle(0, 1, 0, 8'hFF, 4'h0, '0, 0, 0, '0, '0, '0);
    idle(1'b0);
    chk("t6_read_ff", 64'(last_r0), 64'(0));
`endif

    // Preload every word so the reference image is fully known.
    for (int i = 0; i < 256; i++) begin
      cycle(0, 1, 1, AW'(i), 4'hF, DW'($urandom), 0, 0, '0, '0, '0);
    end

    // Test 1: write then read back on requester 0
    cycle(0, 1, 1, 8'h10, 4'hF, 32'hAABBCCDD, 0, 0, '0, '0, '0);
    cycle(0, 1, 0, 8'h10, 4'h0, '0, 0, 0, '0, '0, '0);
    idle(1'b0);
    chk("t1_rdata", 64'(last_r0), 64'(32'hAABBCCDD));

    // Test 2: partial-mask write then read on requester 1
    cycle(0, 0, 0, '0, '0, '0, 1, 1, 8'h10, 4'h5, 32'h11223344);
    cycle(0, 0, 0, '0, '0, '0, 1, 0, 8'h10, 4'h0, '0);
    idle(1'b0);
    chk("t2_rdata", 64'(last_r1), 64'(32'hAA22CC44));

    // Test 3: both requesters reading continuously alternate 0,1,0,1,...
    grants.delete();
    for (int i = 0; i < 6; i++) begin
      cycle(0, 1, 0, AW'(2 * i), '0, '0, 1, 0, AW'(2 * i + 1), '0, '0);
    end
    idle(1'b0);
    chk("t3_grant_count", 64'(grants.size()), 64'(6));
    for (int i = 0; i < 6 && i < grants.size(); i++) begin
      chk("t3_grant_order", 64'(grants[i]), 64'(i % 2));
    end

    // Test 4: requester 1 alone three times, then contention favours 0
    grants.delete();
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, '0, '0, '0, 1, 0, AW'(i), '0, '0);
    cycle(0, 1, 0, 8'h20, '0, '0, 1, 0, 8'h21, '0, '0);
    idle(1'b0);
    chk("t4_grant_count", 64'(grants.size()), 64'(4));
    if (grants.size() == 4) begin
      chk("t4_g0", 64'(grants[0]), 64'(1));
      chk("t4_g1", 64'(grants[1]), 64'(1));
      chk("t4_g2", 64'(grants[2]), 64'(1));
      chk("t4_g3", 64'(grants[3]), 64'(0));
    end

    // Test 5: reset right after an accepted read drops the response
    cycle(0, 1, 0, 8'h10, '0, '0, 0, 0, '0, '0, '0);
    idle(1'b1);
    idle(1'b0);
    chk("t5_resp0_dropped", 64'(last_r0 === 32'hAA22CC44 && resp0_valid), 64'(0));
    wait_init();

    // Randomized traffic over a small address window to provoke hazards
    for (int i = 0; i < 800; i++) rand_cycle();
    idle(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_rw_arbiter.md
Name: sram_rw_arbiter

Overview:
- Shares one single-port, byte-masked RW SRAM macro (256x32, 4-bit byte mask, registered read address, 1-cycle read latency) between two requesters.
- Each requester uses a valid/ready request channel and a fire-and-forget read-response channel.
- Round-robin arbitration; at most one memory access per cycle.
- Sits between the pipeline clients and the SRAM macro; its mem_* ports connect directly to the macro RW0 port.

Parameters:
ADDR_W, 8, address width; memory depth = 2^ADDR_W
DATA_W, 32, data width
MASK_W, 4, write-mask width; one bit per 8-bit byte; must equal DATA_W/8

Ports:
clock  input  1  single clock, rising edge
reset  input  1  synchronous, active-high
req0_valid  input  1  requester 0 has a request
req0_ready  output  1  requester 0 granted this cycle
req0_addr  input  ADDR_W  word address
req0_write  input  1  1 = masked write, 0 = read
req0_wmask  input  MASK_W  byte enables; ignored on reads
req0_wdata  input  DATA_W  write data
resp0_valid  output  1  read data valid for requester 0
resp0_rdata  output  DATA_W  read data for requester 0
req1_*, resp1_*  same set as requester 0, for requester 1
mem_en  output  1  to macro RW0_en
mem_wmode  output  1  to macro RW0_wmode
mem_addr  output  ADDR_W  to macro RW0_addr
mem_wmask  output  MASK_W  to macro RW0_wmask
mem_wdata  output  DATA_W  to macro RW0_wdata
mem_rdata  input  DATA_W  from macro RW0_rdata
init_done  output  1  block accepting requests

Behaviour:
- Reset (synchronous, active-high):
  - While reset is high: req*_ready=0, mem_en=0, resp*_valid=0, init_done=0.
  - Round-robin pointer resets to favour requester 0.
- Arbitration (combinational within a cycle, only when init_done=1):
  - Only req0_valid high: grant 0. Only req1_valid high: grant 1.
  - Both high: grant the requester not granted most recently.
  - reqN_ready=1 only for the granted requester. A request is accepted when valid & ready.
  - The pointer updates only on an accepted request. Idle cycles leave it unchanged.
- Memory drive (combinational from the granted request):
  - mem_en = accept; mem_wmode = req_write; mem_addr, mem_wmask, mem_wdata pass through from the granted requester.
  - When no request is accepted: mem_en=0, and the other mem_* outputs are don't-care (drive 0).
- Read latency:
  - A read accepted in cycle T raises respN_valid for exactly one cycle, T+1.
  - respN_rdata = mem_rdata in that cycle.
  - A 1-bit owner register plus a read-pending flag records the destination.
  - No response backpressure: the requester must sample the response in that cycle.
- Writes produce no response. The macro updates only the masked bytes.
- A write with wmask=0 is accepted and drives mem_en=1, but changes no data.
- Hazards:
  - Read in T+1 of an address written in T returns the new data; the write commits at the edge ending T.
  - A back-to-back read/write pair to the same address from different requesters is serviced in grant order, with no reordering.
- respN_rdata when respN_valid=0: hold the last value. It is not checked.
- Reset mid-operation: a pending read response is dropped; resp*_valid=0 the cycle after reset asserts.
- Throughput: 1 access/cycle sustained. With both requesters continuously valid, grants alternate 0,1,0,1.

Optional Feature:
- Macro: SRAM_ARB_ZERO_INIT_EN.
- Defined:
  - After reset deasserts, an INIT state writes 0 with mask all-ones to addresses 0..2^ADDR_W-1, one per cycle, using an ADDR_W-bit counter.
  - During INIT: req*_ready=0 and init_done=0.
  - When the counter reaches its maximum, the state moves to RUN and init_done=1 from the next cycle. For ADDR_W=8 this is 256 cycles after reset deasserts.
  - Reset during INIT restarts the sweep at address 0.
- Undefined: no INIT state; init_done=1 from the first cycle after reset deasserts; memory contents are uninitialised.

Test Plan:
1. Reset, then req0 write addr 0x10, wdata 0xAABBCCDD, wmask 0xF. Next cycle req0 read 0x10 -> resp0_valid=1 one cycle later, resp0_rdata=0xAABBCCDD; resp1_valid stays 0.
2. After test 1, req1 write addr 0x10, wdata 0x11223344, wmask 0x5, then req1 read 0x10 -> resp1_rdata=0xAA22CC44.
3. req0_valid and req1_valid held high with reads for 6 cycles -> grants 0,1,0,1,0,1. Each resp carries the correct owner and data; never both resp valid in one cycle.
4. req1 alone valid for 3 cycles, then both valid -> req1 granted 3 times, then req0 granted first on contention.
5. Read accepted in cycle T, reset asserted in T+1 -> resp*_valid=0 in T+1 and T+2; ready=0 while reset is high.
6. With SRAM_ARB_ZERO_INIT_EN: release reset -> init_done=0 and ready=0 for 256 cycles; mem_en=1, wmode=1, wmask=0xF, addr 0..255. Afterwards, read addr 0xFF -> 0x00000000.
